// File: rtl/capsense_scanner.sv
// capsense_scanner: multiplexed RC charge-time capacitive touch scanner with per-channel thresholds.
// Optional IIR count filter is built in when CAPSENSE_FILTER_EN is defined.
module capsense_scanner #(
  parameter int unsigned NUM_SENSE        = 4,
  parameter int unsigned COUNT_W          = 16,
  parameter int unsigned DISCHARGE_CYCLES = 256,
  parameter int unsigned TIMEOUT          = 16'hFFFF,
  parameter int unsigned THRESH_DEFAULT   = 400,
  parameter int unsigned HYST             = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_SENSE-1:0] sense_in,
  output logic [NUM_SENSE-1:0] sense_oe,
  input  logic                 thr_we,
  input  logic [4:0]           thr_addr,
  input  logic [COUNT_W-1:0]   thr_data,
  input  logic [5:0]           rd_addr,
  output logic [COUNT_W+1:0]   rd_data,
  output logic [NUM_SENSE-1:0] touched,
  output logic                 scan_done
);
  localparam int unsigned CH_W  = (NUM_SENSE > 1) ? $clog2(NUM_SENSE) : 1;
  localparam int unsigned TMR_W = $clog2(DISCHARGE_CYCLES + 1);
  localparam int unsigned RD_W  = COUNT_W + 2;
  localparam int unsigned CMP_W = COUNT_W + 1;

  typedef enum logic [1:0] {DISCH, MEAS, UPDATE, NEXT} state_t;

  state_t               state, state_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [COUNT_W-1:0]   cnt, cnt_nxt;
  logic                 meas_tmo, meas_tmo_nxt;
  logic [CH_W-1:0]      ch, ch_nxt;
  logic [NUM_SENSE-1:0] sense_oe_nxt;
  logic                 scan_done_nxt;
  logic [NUM_SENSE-1:0] sync1, synced;

  logic [COUNT_W-1:0]   count_q [NUM_SENSE];
  logic [COUNT_W-1:0]   thr_q   [NUM_SENSE];
  logic [NUM_SENSE-1:0] tmo_q;
  logic [COUNT_W-1:0]   val;
  logic [CMP_W-1:0]     set_lvl;
  logic                 touch_nxt;

  // Two-flop synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= '0;
      synced <= '0;
    end else begin
      sync1  <= sense_in;
      synced <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= DISCH;
      timer     <= '0;
      cnt       <= '0;
      meas_tmo  <= 1'b0;
      ch        <= '0;
      sense_oe  <= '1;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      cnt       <= cnt_nxt;
      meas_tmo  <= meas_tmo_nxt;
      ch        <= ch_nxt;
      sense_oe  <= sense_oe_nxt;
      scan_done <= scan_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    cnt_nxt       = cnt;
    meas_tmo_nxt  = meas_tmo;
    ch_nxt        = ch;
    scan_done_nxt = 1'b0;
    sense_oe_nxt  = '1;
    unique case (state)
      DISCH: begin
        if (timer == TMR_W'(DISCHARGE_CYCLES - 1)) begin
          state_nxt    = MEAS;
          cnt_nxt      = '0;
          meas_tmo_nxt = 1'b0;
        end else begin
          timer_nxt = TMR_W'(timer + 1'b1);
        end
      end
      MEAS: begin
        // A real pad edge wins over a timeout landing on the same clock
        if (synced[ch]) begin
          state_nxt = UPDATE;
        end else if (cnt == COUNT_W'(TIMEOUT)) begin
          state_nxt    = UPDATE;
          meas_tmo_nxt = 1'b1;
        end else begin
          cnt_nxt = COUNT_W'(cnt + 1'b1);
        end
      end
      UPDATE: state_nxt = NEXT;
      NEXT: begin
        state_nxt = DISCH;
        timer_nxt = '0;
        if (ch == CH_W'(NUM_SENSE - 1)) begin
          ch_nxt        = '0;
          scan_done_nxt = 1'b1;
        end else begin
          ch_nxt = CH_W'(ch + 1'b1);
        end
      end
      default: state_nxt = DISCH;
    endcase
    if (state_nxt == MEAS) sense_oe_nxt[ch] = 1'b0;
  end

`ifdef CAPSENSE_FILTER_EN
  localparam int unsigned SUM_W = COUNT_W + 3;
  logic [RD_W-1:0]  avg_q [NUM_SENSE];
  logic [RD_W-1:0]  avg_nxt;
  logic [SUM_W-1:0] avg_sum;

  // avg holds value<<2; a timeout bypasses the filter so it is reported at once
  always_comb begin
    avg_sum = SUM_W'(avg_q[ch]) + SUM_W'(cnt) - SUM_W'(avg_q[ch] >> 2);
    if (meas_tmo) avg_nxt = RD_W'(TIMEOUT) << 2;
    else          avg_nxt = RD_W'(avg_sum);
    val = avg_nxt[RD_W-1:2];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SENSE; i++) avg_q[i] <= '0;
    end else if (state == UPDATE) begin
      avg_q[ch] <= avg_nxt;
    end
  end
`else
  assign val = cnt;
`endif

  // Hysteresis compare on the value about to be stored
  always_comb begin
    set_lvl   = CMP_W'(thr_q[ch]) + CMP_W'(HYST);
    touch_nxt = touched[ch];
    if (meas_tmo)                       touch_nxt = 1'b0;
    else if (CMP_W'(val) >= set_lvl)    touch_nxt = 1'b1;
    else if (val < thr_q[ch])           touch_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SENSE; i++) begin
        count_q[i] <= '0;
        thr_q[i]   <= COUNT_W'(THRESH_DEFAULT);
      end
      tmo_q   <= '0;
      touched <= '0;
    end else begin
      if (state == UPDATE) begin
        count_q[ch] <= val;
        tmo_q[ch]   <= meas_tmo;
        touched[ch] <= touch_nxt;
      end
      if (thr_we && (32'(thr_addr) < NUM_SENSE)) thr_q[CH_W'(thr_addr)] <= thr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < NUM_SENSE) begin
      rd_data <= {tmo_q[CH_W'(rd_addr)], touched[CH_W'(rd_addr)], count_q[CH_W'(rd_addr)]};
    end else if (32'(rd_addr) == NUM_SENSE) begin
      rd_data <= RD_W'(touched);
    end else if (32'(rd_addr) == NUM_SENSE + 1) begin
      rd_data <= RD_W'(ch);
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_capsense_scanner.sv
// Directed bench for capsense_scanner: a pad model releases each pad a programmable time after
// sense_oe drops; dly[i] includes the 2-clock synchroniser latency, so the stored count equals dly[i].
`timescale 1ns/1ps
module tb_capsense_scanner;
  localparam int unsigned NS  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned RW  = CW + 2;
  localparam int unsigned TMO = 1000;
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NS-1:0] sense_in;
  logic [NS-1:0] sense_oe;
  logic          thr_we;
  logic [4:0]    thr_addr;
  logic [CW-1:0] thr_data;
  logic [5:0]    rd_addr;
  logic [RW-1:0] rd_data;
  logic [NS-1:0] touched;
  logic          scan_done;

  int checks = 0;
  int fails  = 0;
  int dly [NS];
  int rel [NS];
  logic [NS-1:0] pad;

  capsense_scanner #(
    .NUM_SENSE(NS), .COUNT_W(CW), .DISCHARGE_CYCLES(8), .TIMEOUT(TMO),
    .THRESH_DEFAULT(400), .HYST(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sense_in(sense_in), .sense_oe(sense_oe),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .touched(touched), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Pad goes high (dly-2) clocks after the edge that released it
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (sense_oe[i] !== 1'b0) begin
        rel[i] <= 0;
        pad[i] <= 1'b0;
      end else begin
        rel[i] <= rel[i] + 1;
        pad[i] <= (rel[i] + 1 >= dly[i] - 2);
      end
    end
  end
  assign sense_in = pad;

  task automatic wait_scan(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_oe(input logic [NS-1:0] pat, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (sense_oe === pat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rd(input int a, output logic [RW-1:0] d);
    rd_addr = 6'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset;
    int n;
    logic [RW-1:0] d;
    reset_n = 1'b0; thr_we = 1'b0; thr_addr = '0; thr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (sense_oe !== 4'hF) begin fails++; $display("FAIL reset_oe got %h expected f", sense_oe); end
    checks++; if (touched !== 4'h0) begin fails++; $display("FAIL reset_touched got %h expected 0", touched); end
    checks++; if (scan_done !== 1'b0) begin fails++; $display("FAIL reset_scan_done got %b expected 0", scan_done); end
    checks++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %0d expected 0", rd_data); end
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (sense_oe !== 4'hF) break;
    end
    checks++; if (n != 8) begin fails++; $display("FAIL discharge_len got %0d expected 8", n); end
    checks++; if (sense_oe !== 4'hE) begin fails++; $display("FAIL first_meas_oe got %h expected e", sense_oe); end
    for (int a = 0; a < NS; a++) begin
      rd(a, d);
      checks++; if (d !== '0) begin fails++; $display("FAIL reset_count%0d got %0d expected 0", a, d); end
    end
    rd(NS + 1, d);
    checks++; if (d !== '0) begin fails++; $display("FAIL reset_ch got %0d expected 0", d); end
  endtask

  task automatic test_basic_scan;
    bit ok;
    logic [RW-1:0] d;
    wait_scan(ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_scan_done got timeout expected pulse"); end
    @(negedge clk);
    checks++; if (scan_done !== 1'b0) begin fails++; $display("FAIL scan_done_width got %b expected 0", scan_done); end
    for (int a = 0; a < NS; a++) begin
      rd(a, d);
      checks++; if (d !== RW'(100)) begin fails++; $display("FAIL basic_count%0d got %0d expected 100", a, d); end
    end
    rd(NS, d);
    checks++; if (d !== '0) begin fails++; $display("FAIL basic_touch_vec got %0d expected 0", d); end
    rd(NS + 1, d);
    checks++; if (d !== '0) begin fails++; $display("FAIL basic_ch got %0d expected 0", d); end
    rd(NS + 2, d);
    checks++; if (d !== '0) begin fails++; $display("FAIL rd_unmapped6 got %0d expected 0", d); end
    rd(63, d);
    checks++; if (d !== '0) begin fails++; $display("FAIL rd_unmapped63 got %0d expected 0", d); end
  endtask

  task automatic test_hysteresis;
    int   hd [7];
    logic ht [7];
    bit ok;
    logic [RW-1:0] d;
    logic [RW-1:0] e;
    hd = '{500, 410, 400, 399, 415, 416, 100};
    ht = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      dly[2] = hd[k];
      wait_scan(ok);
      checks++; if (!ok) begin fails++; $display("FAIL hyst_scan%0d got timeout expected pulse", k); end
      checks++;
      if (touched !== (NS'(ht[k]) << 2)) begin
        fails++; $display("FAIL hyst_touched dly=%0d got %b expected %b", hd[k], touched, NS'(ht[k]) << 2);
      end
      e = {1'b0, ht[k], CW'(hd[k])};
      rd(2, d);
      checks++; if (d !== e) begin fails++; $display("FAIL hyst_rd2 dly=%0d got %0d expected %0d", hd[k], d, e); end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    logic [RW-1:0] d;
    dly[1] = 500;
    wait_scan(ok);
    checks++; if (!ok || touched !== 4'b0010) begin fails++; $display("FAIL tmo_pre_touch got %b expected 0010", touched); end
    dly[1] = NEVER;
    dly[2] = 120;
    wait_scan(ok);
    checks++; if (!ok) begin fails++; $display("FAIL tmo_scan got timeout expected pulse"); end
    rd(1, d);
    checks++; if (d !== {1'b1, 1'b0, CW'(TMO)}) begin fails++; $display("FAIL tmo_rd1 got %0d expected %0d", d, {1'b1, 1'b0, CW'(TMO)}); end
    checks++; if (touched !== 4'b0000) begin fails++; $display("FAIL tmo_touched got %b expected 0000", touched); end
    rd(2, d);
    checks++; if (d !== RW'(120)) begin fails++; $display("FAIL tmo_next_ch got %0d expected 120", d); end
    dly[1] = 100;
    wait_scan(ok);
    rd(1, d);
    checks++; if (!ok || d !== RW'(100)) begin fails++; $display("FAIL tmo_recover got %0d expected 100", d); end
  endtask

  task automatic test_thr_write;
    bit ok;
    logic [RW-1:0] d;
    dly[3] = 70;
    wait_oe(4'b0111, ok);
    checks++; if (!ok) begin fails++; $display("FAIL thr_meas3 got oe %h expected 7", sense_oe); end
    thr_we = 1'b1; thr_addr = 5'd3; thr_data = CW'(50);
    @(negedge clk);
    thr_we = 1'b0;
    wait_scan(ok);
    checks++; if (!ok || touched !== 4'b1000) begin fails++; $display("FAIL thr_write_touch got %b expected 1000", touched); end
    rd(3, d);
    checks++; if (d !== {1'b0, 1'b1, CW'(70)}) begin fails++; $display("FAIL thr_write_rd3 got %0d expected %0d", d, {1'b0, 1'b1, CW'(70)}); end
    thr_we = 1'b1; thr_addr = 5'd7; thr_data = CW'(1000);
    @(negedge clk);
    thr_we = 1'b0;
    wait_scan(ok);
    checks++; if (!ok || touched !== 4'b1000) begin fails++; $display("FAIL thr_oob_ignored got %b expected 1000", touched); end
  endtask

  task automatic test_reset_mid_meas;
    bit ok;
    logic [RW-1:0] d;
    wait_oe(4'b1101, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rst_meas1 got oe %h expected d", sense_oe); end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (sense_oe !== 4'hF) begin fails++; $display("FAIL rst_mid_oe got %h expected f", sense_oe); end
    checks++; if (touched !== 4'h0) begin fails++; $display("FAIL rst_mid_touched got %b expected 0000", touched); end
    checks++; if (rd_data !== '0) begin fails++; $display("FAIL rst_mid_rd got %0d expected 0", rd_data); end
    reset_n = 1'b1;
    rd(NS + 1, d);
    checks++; if (d !== '0) begin fails++; $display("FAIL rst_mid_ch got %0d expected 0", d); end
    for (int a = 0; a < NS; a++) begin
      rd(a, d);
      checks++; if (d !== '0) begin fails++; $display("FAIL rst_mid_count%0d got %0d expected 0", a, d); end
    end
    wait_scan(ok);
    checks++; if (!ok || touched !== 4'b0000) begin fails++; $display("FAIL rst_thr_default got %b expected 0000", touched); end
    rd(3, d);
    checks++; if (d !== RW'(70)) begin fails++; $display("FAIL rst_rescan3 got %0d expected 70", d); end
  endtask

`ifdef CAPSENSE_FILTER_EN
  task automatic test_filter;
    int exp [4];
    bit ok;
    logic [RW-1:0] d;
    exp = '{50, 87, 115, 137};
    for (int i = 0; i < NS; i++) dly[i] = 200;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_scan(ok);
      rd(0, d);
      checks++; if (!ok || d !== RW'(exp[k])) begin fails++; $display("FAIL filter_scan%0d got %0d expected %0d", k, d, exp[k]); end
    end
    repeat (26) wait_scan(ok);
    rd(3, d);
    checks++; if (d !== RW'(200)) begin fails++; $display("FAIL filter_converge got %0d expected 200", d); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NS; i++) dly[i] = 100;
    test_reset;
`ifdef CAPSENSE_FILTER_EN
    test_filter;
`else
    test_basic_scan;
    test_hysteresis;
    test_timeout;
    test_thr_write;
    test_reset_mid_meas;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
